// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: single-port memory arbiter between instruction fetch and load/store.
// Data wins by default; a starvation counter forces fetch after MAX_WAIT consecutive denials.
module mem_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_func3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   output logic              mem_write,
   output logic              mem_read,
   output logic              mem_inst,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } last_e;

   localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

   last_e             last_q, last_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              d_read_q, d_read_d;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
   logic              grant_if, grant_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q     <= IDLE;
         wait_cnt_q <= 4'd0;
         d_read_q   <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         last_q     <= last_d;
         wait_cnt_q <= wait_cnt_d;
         d_read_q   <= d_read_d;
         if (grant_if) if_rdata_q <= mem_rdata;
         if (d_read_d) d_rdata_q  <= mem_rdata;
      end
   end

   // Everything combinational is gated by reset so outputs drop without a clock edge.
   always_comb begin
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      stall      = 1'b0;
      wait_cnt_d = 4'd0;
      last_d     = IDLE;
      d_read_d   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_func3  = 3'b000;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      mem_inst   = 1'b0;

      if (reset) begin
         if (if_req && d_req) begin
            stall = 1'b1;
            if (wait_cnt_q >= C_MAX_WAIT) begin
               grant_if = 1'b1;
            end else begin
               grant_d    = 1'b1;
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end else if (if_req) begin
            grant_if = 1'b1;
         end else if (d_req) begin
            grant_d = 1'b1;
         end

         if (grant_if) begin
            last_d    = FETCH;
            mem_inst  = 1'b1;
            mem_read  = 1'b1;
            mem_func3 = 3'b010;
            mem_addr  = if_addr;
         end else if (grant_d) begin
            last_d    = DATA;
            d_read_d  = ~d_we;
            mem_addr  = d_addr;
            mem_func3 = d_func3;
            mem_wdata = d_wdata;
            mem_write = d_we;
            mem_read  = ~d_we;
         end
      end
   end

   assign if_gnt    = grant_if;
   assign d_gnt     = grant_d;
   assign if_rvalid = (last_q == FETCH);
   assign d_rvalid  = (last_q == DATA) && d_read_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between the core's instruction-fetch port and its load/store port, so the memory sees at most one access per cycle. Data accesses win by default. A starvation counter forces a fetch grant after `MAX_WAIT` consecutive fetch denials. Read data is registered and returned to the winning requester one cycle after its grant. The block sits between the pipeline front/back ends and the memory, and drives `stall` into the hazard logic.

## Interface
- `ADDR_W`, 8: byte address width, fetch and data ports.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 3: consecutive fetch denials before fetch is forced; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  **asynchronous, active-low** reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address, relative to instruction region.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid (registered).
- `if_rdata`  out  DATA_W  fetched instruction.
- `d_req`  in  1  data request; held with fields until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_func3`  in  3  access size/sign, RV32 encoding.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data granted this cycle.
- `d_rvalid`  out  1  load data valid (registered; never set for stores).
- `d_rdata`  out  DATA_W  load data.
- `stall`  out  1  `if_req & d_req` this cycle, and the loser is not granted.
- `mem_addr`  out  ADDR_W  to memory.
- `mem_wdata`  out  DATA_W  to memory.
- `mem_func3`  out  3  to memory; forced to `3'b010` on fetch.
- `mem_write`  out  1  memory write strobe.
- `mem_read`  out  1  memory read strobe.
- `mem_inst`  out  1  1 = instruction-region access (memory applies its offset).
- `mem_rdata`  in  DATA_W  combinational read data from memory.

## Operation
- FSM state is `last` ∈ {IDLE, FETCH, DATA}: the most recent grant. Starvation counter `wait_cnt` is 4 bits.
- Grant decision is combinational each cycle:
  - Neither request: no grant. `mem_read = mem_write = 0`, next state IDLE.
  - Only one request: grant that requester.
  - Both, with `wait_cnt < MAX_WAIT`: grant data, `wait_cnt <= wait_cnt + 1`.
  - Both, with `wait_cnt == MAX_WAIT`: grant fetch.
- `wait_cnt` clears on any fetch grant and on any cycle with `if_req = 0`. It saturates at `MAX_WAIT`.
- Fetch grant drives the memory as follows:
  - `mem_inst = 1`, `mem_read = 1`, `mem_write = 0`, `mem_func3 = 3'b010`.
  - `mem_addr = if_addr`.
- Data grant drives the memory as follows:
  - `mem_inst = 0`, `mem_addr = d_addr`, `mem_func3 = d_func3`, `mem_wdata = d_wdata`.
  - `mem_write = d_we`, `mem_read = ~d_we`.
- Response capture at the posedge ending a read-grant cycle:
  - `mem_rdata` is latched into the winner's rdata register and its rvalid is set.
  - rvalid is a one-cycle pulse; rdata holds until the next capture.
- Store-then-load to the same address in consecutive cycles returns the new data: the write commits at the grant edge.
- Requester fields are sampled only in the grant cycle. Changing them while the request is pending is legal; the granted-cycle values win.
- `mem_wdata` = 0 whenever no data grant is active. Memory-side outputs are deterministic.

## Timing
- Reset (`reset = 0`, asynchronous) forces every output to 0 immediately. This includes `if_gnt`, `d_gnt`, `mem_read`, `mem_write`, `stall`, both rvalids and both rdatas. The FSM goes to IDLE and `wait_cnt` to 0.
- Reset mid-access: any pending rvalid is dropped, and no write commits on an edge while `reset = 0`. After release, the first edge behaves as from IDLE.
- Grant latency is 0 cycles, since `gnt` is asserted in the same cycle as `req` if it wins.
- Read latency: rvalid is asserted exactly 1 cycle after the grant.
- Store: done at the grant edge, with no response.
- Worst-case fetch wait under a continuous data stream is `MAX_WAIT` cycles, and fetch is granted in cycle `MAX_WAIT + 1`.
- Back-to-back grants to the same requester are allowed every cycle.
- Throughput is 1 access per cycle.

## Test plan
- **Reset:** hold `reset = 0` with `if_req = d_req = 1` → all outputs 0 with no posedge needed. Release → first grant goes to data.
- **Fetch only:** `if_req = 1`, `if_addr = 8'h00`, instruction memory word = `32'h01100093` → same cycle `if_gnt = 1`, `mem_inst = 1`, `mem_func3 = 3'b010`. Next cycle `if_rvalid = 1`, `if_rdata = 32'h01100093`.
- **Load:** `d_req = 1`, `d_we = 0`, `d_func3 = 3'b010`, `d_addr = 4`, memory word = 9 → `d_gnt = 1`, `mem_inst = 0`. Next cycle `d_rdata = 32'd9`, `d_rvalid = 1`, `if_rvalid = 0`.
- **Conflict:** both requesting in one cycle, then data drops → cycle 0 `d_gnt = 1`, `stall = 1`. Cycle 1 `if_gnt = 1`, `stall = 0`.
- **Starvation:** `MAX_WAIT = 3`, `d_req` and `if_req` held high for 6 cycles → `d_gnt` in cycles 0–2, `if_gnt` in cycle 3, `d_gnt` in cycles 4–5 (`wait_cnt` restarts).
- **Store/load ordering:** `sb` with `d_wdata = 32'h000000AB` to address 8, then `lw` at address 8 next cycle → `d_rdata = 32'h000000AB`. Also pulse `reset` low during a granted store → memory unchanged.
